adaptive_signal_ctrl: RTL and testbench
=======================================

Name: adaptive_signal_ctrl

Overview:
- Parametrised N-approach adaptive traffic-signal controller: the next generation of the adaptation block.
- At the start of every signal cycle it snapshots the per-approach vehicle counts and computes green times proportional to queue share. A sequential shift-subtract divider does the division; results are clamped to [TG_MIN, TG_MAX].
- It then sequences GREEN → YELLOW → ALL-RED through each approach in index order, driving the per-approach lamp codes.
- Mode input selects fixed, adaptive, hold or stop operation.

Parameters:
- NUM_DIR, 4, number of approaches (≥2).
- CNT_W, 8, width of each vehicle count.
- TG_W, 8, width of each green time, in seconds.
- CYCLE_BUDGET, 216, total green seconds shared per cycle; must be < 2^TG_W.
- TG_MIN, 10, minimum green (≥1).
- TG_MAX, 90, maximum green.
- YELLOW_T, 3, yellow duration in ticks.
- ALLRED_T, 1, all-red clearance in ticks.
- TICK_DIV, 10, clk cycles per 1-second tick.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  2  00 fixed split, 01 adaptive, 10 hold previous times, 11 stop (all red).
- cnt_in  in  NUM_DIR*CNT_W  vehicle counts; approach i at bits [i*CNT_W +: CNT_W].
- tg_out  out  NUM_DIR*TG_W  green times in use; same packing as cnt_in.
- tg_valid  out  1  one-cycle pulse when tg_out updates.
- light  out  NUM_DIR*2  per approach: 00 red, 01 green, 10 yellow.
- green_dir  out  clog2(NUM_DIR)  approach currently in GREEN/YELLOW/ALLRED.
- timer  out  TG_W  ticks remaining in the current phase.
- busy  out  1  high while in COMPUTE.

Behaviour:
- Reset values (asserted asynchronously):
  - state = IDLE, all light = 00, green_dir = 0, timer = 0, busy = 0, tg_valid = 0.
  - Every tg_out field = CYCLE_BUDGET/NUM_DIR, floored (54 with defaults).
  - Prescaler = 0.
  - Reset asserted mid-operation aborts immediately to these values.
- States: IDLE, COMPUTE, GREEN, YELLOW, ALLRED.
- IDLE:
  - Goes to COMPUTE on the next clk if mode != 11.
  - Otherwise stays in IDLE with all lamps red.
- COMPUTE, fixed latency LAT = 2 + NUM_DIR*(DW+1) cycles, where DW = CNT_W+TG_W (70 with defaults):
  - Cycle 0: latch cnt_in and mode.
  - Cycle 1: register SUM, width CNT_W+clog2(NUM_DIR).
  - Then per approach i (DW+1 cycles each): q_i = floor(CYCLE_BUDGET*N_i / SUM), then clamped to [TG_MIN, TG_MAX].
  - Latched mode 01 with SUM == 0: all approaches get the equal split.
  - Latched mode 00: equal split; the divider still runs (deterministic latency).
  - Latched mode 10: tg_out is unchanged and tg_valid does not pulse.
  - Modes 00/01: on the last COMPUTE cycle, all tg_out fields update together and tg_valid = 1 on the following cycle.
  - Next state is GREEN with green_dir = first served approach.
  - busy = 1 throughout COMPUTE; all lamps are red.
- Phase timing:
  - On entry to GREEN, YELLOW or ALLRED: prescaler clears to 0 and timer loads tg_out[green_dir], YELLOW_T or ALLRED_T respectively.
  - Tick when prescaler == TICK_DIV-1. The prescaler wraps to 0 and timer decrements on each tick.
  - When timer == 1 and a tick occurs, the FSM advances. Each phase therefore lasts exactly load*TICK_DIV clk cycles.
- Lamps:
  - Only light[green_dir] is non-red: 01 in GREEN, 10 in YELLOW.
  - ALLRED: all lamps 00.
- Advance from ALLRED:
  - Goes to the next served approach in GREEN.
  - After the last approach, goes to IDLE. IDLE samples mode, so the next cycle always recomputes.
- tg_out and mode changes mid-cycle do not affect the running cycle.
- Arithmetic:
  - All unsigned; division floors.
  - q_i ≤ CYCLE_BUDGET, so no overflow before the clamp.

Optional Feature:
- Macro ASC_SKIP_EMPTY_EN.
- Defined: in latched mode 01 with SUM > 0, approaches whose snapshot count is 0 are skipped entirely (no GREEN/YELLOW/ALLRED). Their tg_out field is 0.
- Not defined: every approach is served; zero-count approaches get TG_MIN.

Test Plan:
- Reset low, then high with mode = 11 → stays IDLE, all light = 00, tg_out = {54,54,54,54}, busy = 0.
- TICK_DIV = 2, mode = 01, counts {43,22,20,15} → busy for 70 cycles, then tg_valid pulses and tg_out = {90,47,43,32}. Approach 0 green for exactly 180 clk, yellow 6, all-red 2, then approach 1 green.
- mode = 01, counts all 0 → tg_out = {54,54,54,54}; each approach green for 54 ticks.
- mode = 00, counts {200,1,1,1} → tg_out = {54,54,54,54}, tg_valid pulses. Then mode = 10 with new counts → tg_out unchanged and no tg_valid at the next COMPUTE.
- Counts {0,100,0,100}, mode = 01:
  - Without macro → tg_out = {10,90,10,90}.
  - With ASC_SKIP_EMPTY_EN → tg_out = {0,90,0,90}; green_dir sequence 1,3 only.
- Reset pulsed low mid-GREEN of approach 2 → same edge: all lamps red, state IDLE, green_dir = 0, timer = 0, tg_out = equal split.

Source files
------------

// File: rtl/adaptive_signal_ctrl_if.sv
// Bus bundle for the adaptive signal controller.
// Master drives mode and counts; slave returns timings and lamps.
interface adaptive_signal_ctrl_if #(
  parameter int NUM_DIR = 4,
  parameter int CNT_W   = 8,
  parameter int TG_W    = 8
);
  localparam int GW = $clog2(NUM_DIR);

  logic [1:0]             mode;
  logic [NUM_DIR*CNT_W-1:0] cnt_in;
  logic [NUM_DIR*TG_W-1:0]  tg_out;
  logic                   tg_valid;
  logic [NUM_DIR*2-1:0]   light;
  logic [GW-1:0]          green_dir;
  logic [TG_W-1:0]        timer;
  logic                   busy;

  modport master (
    output mode, cnt_in,
    input  tg_out, tg_valid, light,
    input  green_dir, timer, busy
  );

  modport slave (
    input  mode, cnt_in,
    output tg_out, tg_valid, light,
    output green_dir, timer, busy
  );
endinterface

// File: rtl/adaptive_signal_ctrl.sv
// N-approach adaptive traffic-signal controller with shift-subtract divider.
// Optional ASC_SKIP_EMPTY_EN: skip zero-count approaches in adaptive mode.
module adaptive_signal_ctrl #(
  parameter int NUM_DIR      = 4,
  parameter int CNT_W        = 8,
  parameter int TG_W         = 8,
  parameter int CYCLE_BUDGET = 216,
  parameter int TG_MIN       = 10,
  parameter int TG_MAX       = 90,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 1,
  parameter int TICK_DIV     = 10
) (
  input logic clk,
  input logic reset,
  adaptive_signal_ctrl_if.slave bus
);
  localparam int DW = CNT_W + TG_W;
  localparam int SW = CNT_W + $clog2(NUM_DIR);
  localparam int GW = $clog2(NUM_DIR);
  localparam int KW = $clog2(DW + 1);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [TG_W-1:0] EQ = TG_W'(CYCLE_BUDGET / NUM_DIR);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPUTE = 3'd1;
  localparam logic [2:0] S_GREEN   = 3'd2;
  localparam logic [2:0] S_YELLOW  = 3'd3;
  localparam logic [2:0] S_ALLRED  = 3'd4;

  logic [2:0]               state;
  logic [1:0]               pre;
  logic [KW-1:0]            k;
  logic [GW-1:0]            di;
  logic [NUM_DIR*CNT_W-1:0] cnt_l;
  logic [1:0]               mode_l;
  logic [SW-1:0]            sum_r;
  logic [DW-1:0]            quo;
  logic [SW-1:0]            rem;
  logic [TG_W-1:0]          res [NUM_DIR];
  logic [TG_W-1:0]          tg_q [NUM_DIR];
  logic                     tg_valid_r;
  logic [GW-1:0]            gd;
  logic [TG_W-1:0]          timer_r;
  logic [PW-1:0]            pres;

  function automatic logic [TG_W-1:0] clamp(input logic [DW-1:0] q);
    if (q < DW'(TG_MIN)) return TG_W'(TG_MIN);
    else if (q > DW'(TG_MAX)) return TG_W'(TG_MAX);
    else return q[TG_W-1:0];
  endfunction

  function automatic logic [GW-1:0] pick(
    input logic [NUM_DIR-1:0] m, input int after);
    logic [GW-1:0] p;
    p = '0;
    for (int i = NUM_DIR - 1; i >= 0; i--)
      if (i > after && m[i]) p = GW'(i);
    return p;
  endfunction

  function automatic logic has_after(
    input logic [NUM_DIR-1:0] m, input int after);
    logic h;
    h = 1'b0;
    for (int i = 0; i < NUM_DIR; i++)
      if (i > after && m[i]) h = 1'b1;
    return h;
  endfunction

  logic [SW-1:0]      sum_c;
  logic [CNT_W-1:0]   cnt_cur;
  logic [DW-1:0]      dvd;
  logic [SW:0]        trial;
  logic [SW:0]        diff;
  logic               ge;
  logic [SW-1:0]      rem_n;
  logic [DW-1:0]      quo_n;
  logic [NUM_DIR-1:0] served;
  logic [TG_W-1:0]    tg_next [NUM_DIR];
  logic               upd;
  logic               tick;
  logic               phase_done;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_DIR; i++)
      sum_c = sum_c + SW'(cnt_l[i*CNT_W +: CNT_W]);
  end

  assign cnt_cur = cnt_l[di*CNT_W +: CNT_W];
  assign dvd     = DW'(CYCLE_BUDGET) * {{TG_W{1'b0}}, cnt_cur};
  assign trial   = {rem, quo[DW-1]};
  assign diff    = trial - {1'b0, sum_r};
  assign ge      = trial >= {1'b0, sum_r};
  assign rem_n   = ge ? diff[SW-1:0] : trial[SW-1:0];
  assign quo_n   = {quo[DW-2:0], ge};

  always_comb begin
    served = '1;
`ifdef ASC_SKIP_EMPTY_EN
    for (int i = 0; i < NUM_DIR; i++)
      if (mode_l == 2'b01 && sum_r != '0 &&
          cnt_l[i*CNT_W +: CNT_W] == '0)
        served[i] = 1'b0;
`endif
  end

  // The last quotient is still combinational on the final COMPUTE cycle.
  always_comb begin
    upd = (mode_l == 2'b00) || (mode_l == 2'b01);
    for (int i = 0; i < NUM_DIR; i++) begin
      tg_next[i] = tg_q[i];
      if (mode_l == 2'b00 || (mode_l == 2'b01 && sum_r == '0))
        tg_next[i] = EQ;
      else if (mode_l == 2'b01)
        tg_next[i] = !served[i] ? '0 :
                     (i == NUM_DIR - 1) ? clamp(quo_n) : res[i];
    end
  end

  assign tick       = pres == PW'(TICK_DIV - 1);
  assign phase_done = tick && timer_r <= TG_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pre        <= '0;
      k          <= '0;
      di         <= '0;
      cnt_l      <= '0;
      mode_l     <= '0;
      sum_r      <= '0;
      quo        <= '0;
      rem        <= '0;
      tg_valid_r <= 1'b0;
      gd         <= '0;
      timer_r    <= '0;
      pres       <= '0;
      for (int i = 0; i < NUM_DIR; i++) begin
        res[i]  <= '0;
        tg_q[i] <= EQ;
      end
    end else begin
      tg_valid_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          timer_r <= '0;
          gd      <= '0;
          pres    <= '0;
          pre     <= '0;
          if (bus.mode != 2'b11) state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          unique case (1'b1)
            pre == 2'd0: begin
              cnt_l  <= bus.cnt_in;
              mode_l <= bus.mode;
              pre    <= 2'd1;
            end
            pre == 2'd1: begin
              sum_r <= sum_c;
              pre   <= 2'd2;
              k     <= '0;
              di    <= '0;
            end
            default: begin
              if (k == '0) begin
                quo <= dvd;
                rem <= '0;
                k   <= k + KW'(1);
              end else begin
                quo <= quo_n;
                rem <= rem_n;
                k   <= k + KW'(1);
                if (k == KW'(DW)) begin
                  res[di] <= clamp(quo_n);
                  k       <= '0;
                  di      <= di + GW'(1);
                  if (di == GW'(NUM_DIR - 1)) begin
                    if (upd) begin
                      for (int i = 0; i < NUM_DIR; i++)
                        tg_q[i] <= tg_next[i];
                      tg_valid_r <= 1'b1;
                    end
                    pres <= '0;
                    if (|served) begin
                      state   <= S_GREEN;
                      gd      <= pick(served, -1);
                      timer_r <= tg_next[pick(served, -1)];
                    end else begin
                      state <= S_IDLE;
                    end
                  end
                end
              end
            end
          endcase
        end
        S_GREEN, S_YELLOW, S_ALLRED: begin
          pres <= tick ? '0 : pres + PW'(1);
          if (tick && timer_r != '0) timer_r <= timer_r - TG_W'(1);
          if (phase_done) begin
            unique case (state)
              S_GREEN: begin
                state   <= S_YELLOW;
                timer_r <= TG_W'(YELLOW_T);
              end
              S_YELLOW: begin
                state   <= S_ALLRED;
                timer_r <= TG_W'(ALLRED_T);
              end
              default: begin
                if (has_after(served, int'(gd))) begin
                  state   <= S_GREEN;
                  gd      <= pick(served, int'(gd));
                  timer_r <= tg_q[pick(served, int'(gd))];
                end else begin
                  state   <= S_IDLE;
                  gd      <= '0;
                  timer_r <= '0;
                end
              end
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.light = '0;
    if (state == S_GREEN)  bus.light[gd*2 +: 2] = 2'b01;
    if (state == S_YELLOW) bus.light[gd*2 +: 2] = 2'b10;
    for (int i = 0; i < NUM_DIR; i++)
      bus.tg_out[i*TG_W +: TG_W] = tg_q[i];
  end

  assign bus.tg_valid  = tg_valid_r;
  assign bus.green_dir = gd;
  assign bus.timer     = timer_r;
  assign bus.busy      = state == S_COMPUTE;
endmodule

// File: tb/tb_adaptive_signal_ctrl.sv
// Self-checking bench: per-cycle trace model plus literal spot checks.
// Build with ASC_SKIP_EMPTY_EN to cover the skip-empty variant.
module tb_adaptive_signal_ctrl;
  localparam int ND  = 4;
  localparam int BUD = 216;
  localparam int TMN = 10;
  localparam int TMX = 90;
  localparam int YT  = 3;
  localparam int AT  = 1;
  localparam int TD  = 2;
  localparam int LAT = 2 + ND * (8 + 8 + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adaptive_signal_ctrl_if #(.NUM_DIR(ND), .CNT_W(8), .TG_W(8)) bus ();

  adaptive_signal_ctrl #(
    .NUM_DIR(ND), .CNT_W(8), .TG_W(8), .CYCLE_BUDGET(BUD),
    .TG_MIN(TMN), .TG_MAX(TMX), .YELLOW_T(YT), .ALLRED_T(AT),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        busy;
    logic [7:0]  light;
    logic [1:0]  gd;
    logic        gd_chk;
    logic [7:0]  timer;
    logic [31:0] tg;
    logic        tgv;
  } rec_t;

  rec_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_tg = {4{8'd54}};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d",
               name, $time, act, exp);
    end
  endtask

  task automatic push(input logic busy, input logic [7:0] light,
                      input int gd, input logic gdc, input int timer,
                      input logic [31:0] tg, input logic tgv);
    rec_t r;
    r.busy = busy; r.light = light; r.gd = 2'(gd); r.gd_chk = gdc;
    r.timer = 8'(timer); r.tg = tg; r.tgv = tgv;
    q.push_back(r);
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk("busy", 32'(bus.busy), 32'(r.busy));
      chk("light", 32'(bus.light), 32'(r.light));
      chk("timer", 32'(bus.timer), 32'(r.timer));
      chk("tg_out", bus.tg_out, r.tg);
      chk("tg_valid", 32'(bus.tg_valid), 32'(r.tgv));
      if (r.gd_chk) chk("green_dir", 32'(bus.green_dir), 32'(r.gd));
    end
  end

  task automatic phase(input int d, input logic [1:0] code, input int len,
                       input logic [31:0] tg, inout logic first);
    logic [7:0] lv;
    lv = 8'(code) << (2 * d);
    for (int j = 0; j < len * TD; j++) begin
      push(1'b0, lv, d, 1'b1, len - j / TD, tg, first);
      first = 1'b0;
    end
  endtask

  // Expected trace for one full signal cycle starting from IDLE.
  task automatic plan(input int c0, input int c1, input int c2,
                      input int c3, input logic [1:0] m);
    int c[4];
    int nt[4];
    logic srv[4];
    int sum, qv;
    logic upd, first;
    logic [31:0] ntg;
    c = '{c0, c1, c2, c3};
    sum = 0;
    for (int i = 0; i < ND; i++) begin
      sum += c[i];
      bus.cnt_in[i*8 +: 8] = 8'(c[i]);
      srv[i] = 1'b1;
    end
    bus.mode = m;
    upd = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (m == 2'b00 || (m == 2'b01 && sum == 0)) nt[i] = BUD / ND;
      else if (m == 2'b01) begin
        qv = BUD * c[i] / sum;
        nt[i] = qv < TMN ? TMN : (qv > TMX ? TMX : qv);
`ifdef ASC_SKIP_EMPTY_EN
        if (c[i] == 0) begin nt[i] = 0; srv[i] = 1'b0; end
`endif
      end else begin
        nt[i] = int'(cur_tg[i*8 +: 8]);
        upd = 1'b0;
      end
      ntg[i*8 +: 8] = 8'(nt[i]);
    end
    push(1'b0, 8'd0, 0, 1'b0, 0, cur_tg, 1'b0);
    for (int j = 0; j < LAT; j++)
      push(1'b1, 8'd0, 0, 1'b0, 0, cur_tg, 1'b0);
    first = upd;
    for (int d = 0; d < ND; d++)
      if (srv[d]) begin
        phase(d, 2'b01, nt[d], ntg, first);
        phase(d, 2'b10, YT, ntg, first);
        phase(d, 2'b00, AT, ntg, first);
      end
    cur_tg = ntg;
  endtask

  task automatic drain(input int target);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      if (n > 20000) begin
        $display("FAIL drain_timeout got %0d expected %0d", q.size(), target);
        $fatal(1);
      end
    end while (q.size() > target);
    #1;
  endtask

  initial begin
    int tot;
    reset = 1'b0;
    bus.mode = 2'b11;
    bus.cnt_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_light", 32'(bus.light), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_tg", bus.tg_out, {4{8'd54}});
    chk("idle_gd", 32'(bus.green_dir), 0);
    chk("idle_timer", 32'(bus.timer), 0);
    chk("idle_valid", 32'(bus.tg_valid), 0);
    for (int i = 0; i < 6; i++)
      push(1'b0, 8'd0, 0, 1'b1, 0, cur_tg, 1'b0);
    drain(0);

    plan(43, 22, 20, 15, 2'b01);
    drain(0);
    chk("adapt_tg", bus.tg_out, {8'd32, 8'd43, 8'd47, 8'd90});

    plan(0, 100, 0, 100, 2'b10);
    drain(0);
    chk("hold_tg", bus.tg_out, {8'd32, 8'd43, 8'd47, 8'd90});

    plan(0, 0, 0, 0, 2'b01);
    drain(0);
    chk("zero_tg", bus.tg_out, {4{8'd54}});

    plan(200, 1, 1, 1, 2'b00);
    drain(0);
    chk("fixed_tg", bus.tg_out, {4{8'd54}});

    plan(0, 100, 0, 100, 2'b01);
    drain(0);
`ifdef ASC_SKIP_EMPTY_EN
    chk("skip_tg", bus.tg_out, {8'd90, 8'd0, 8'd90, 8'd0});
`else
    chk("clamp_tg", bus.tg_out, {8'd90, 8'd10, 8'd90, 8'd10});
`endif

    plan(43, 22, 20, 15, 2'b01);
    tot = q.size();
    drain(tot - 381);
    chk("mid_gd", 32'(bus.green_dir), 2);
    chk("mid_light", 32'(bus.light), 32'h10);
    q.delete();
    bus.mode = 2'b11;
    reset = 1'b0;
    #1;
    chk("arst_light", 32'(bus.light), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_gd", 32'(bus.green_dir), 0);
    chk("arst_timer", 32'(bus.timer), 0);
    chk("arst_tg", bus.tg_out, {4{8'd54}});
    chk("arst_valid", 32'(bus.tg_valid), 0);
    cur_tg = {4{8'd54}};
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      push(1'b0, 8'd0, 0, 1'b1, 0, cur_tg, 1'b0);
    drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule
